// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction memory loader.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    DONE = 2'd1,
    OVF  = 2'd2
  } state_e;

  // Wide enough for any supported instruction width; truncated at the use site.
  localparam int unsigned TERM_MAX_W = 256;
  localparam logic [TERM_MAX_W-1:0] TERM_ALL_ONES = '1;

  // Byte counter width: at least 2 bits, enough to count WIDTH/8 bytes.
  function automatic int unsigned bcnt_width(input int unsigned bpw);
    return (bpw <= 4) ? 2 : $clog2(bpw);
  endfunction

endpackage

// File: rtl/inst_mem_ram.sv
// Single-clock RAM: one write port, one registered read port (only the read register is reset).
module inst_mem_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Byte-streamed program loader into instruction RAM with a one-cycle fetch port.
module inst_mem_loader
  import inst_mem_pkg::*;
#(
  parameter int unsigned      DEPTH = 256,
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] TERM  = WIDTH'(TERM_ALL_ONES),
  parameter int unsigned      AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_valid,
  input  logic [7:0]       load_byte,
  output logic             load_ready,
  input  logic             restart,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             loading,
  output logic             load_done,
  output logic             overflow,
  output logic [AW:0]      load_count
);

  localparam int unsigned    BPW       = WIDTH / 8;
  localparam int unsigned    BCW       = bcnt_width(BPW);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);
  localparam logic [AW:0]    FULL_PTR  = (AW + 1)'(DEPTH);

  state_e           state, state_nxt;
  logic [BCW-1:0]   bcnt;
  logic [WIDTH-1:0] shreg;
  logic [AW:0]      wptr;
  logic             oob_q;
  logic [WIDTH-1:0] ram_q;

  logic             accept;
  logic             word_last;
  logic [WIDTH-1:0] word;
  logic             is_term;
  logic             full;
  logic             we;
  logic             rd_req;

  // Restart always wins over a byte or read offered in the same cycle.
  assign accept    = (state == LOAD) && load_valid && !restart;
  assign word_last = accept && (bcnt == LAST_BYTE);
  assign word      = WIDTH'({shreg, load_byte});
  assign is_term   = (word == TERM);
  assign full      = (wptr == FULL_PTR);
  assign we        = word_last && !is_term && !full;
  assign rd_req    = (state == DONE) && rd_en && !restart;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD: begin
        if (!restart && word_last) begin
          if (is_term)   state_nxt = DONE;
          else if (full) state_nxt = OVF;
        end
      end
      DONE, OVF: begin
        if (restart) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Byte packer, write pointer and read bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bcnt     <= '0;
      shreg    <= '0;
      wptr     <= '0;
      rd_valid <= 1'b0;
      oob_q    <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) oob_q <= ({1'b0, rd_addr} >= wptr);
      if (restart) begin
        bcnt  <= '0;
        shreg <= '0;
        wptr  <= '0;
      end else if (accept) begin
        shreg <= word;
        bcnt  <= word_last ? '0 : bcnt + BCW'(1);
        if (we) wptr <= wptr + (AW + 1)'(1);
      end
    end
  end

  inst_mem_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (we),
    .waddr (wptr[AW-1:0]),
    .wdata (word),
    .re    (rd_req),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  // Fetches past the stored program see the terminator.
  assign rd_data    = oob_q ? TERM : ram_q;
  assign load_ready = (state == LOAD);
  assign loading    = (state == LOAD);
  assign load_done  = (state == DONE);
  assign overflow   = (state == OVF);
  assign load_count = wptr;

endmodule
